// File: rtl/interp_coord_gen_pkg.sv
// Shared definitions for the interpolation coordinate generator:
// FSM state encoding, neighbour-phase constants and coordinate limits.
package interp_coord_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Neighbour phase; the two bits map directly onto {sel_y, sel_x}.
  localparam logic [1:0] PH_00 = 2'd0;
  localparam logic [1:0] PH_01 = 2'd1;
  localparam logic [1:0] PH_10 = 2'd2;
  localparam logic [1:0] PH_11 = 2'd3;

  // Default coordinate width and its signed limits.
  localparam int COORD_W_DEF = 8;
  localparam logic [COORD_W_DEF-1:0] COORD_MAX = 8'h7f;
  localparam logic [COORD_W_DEF-1:0] COORD_MIN = 8'h80;

endpackage

// File: rtl/interp_coord_gen_incr_sat.sv
// Combinational signed coordinate plus unsigned offset, saturating at the
// positive limit. Offsets are never negative, so the sum can only overflow
// upwards and the lower limit needs no clamp.
module coord_incr_sat #(
  parameter int W  = 8,
  parameter int OW = 1
) (
  input  logic [W-1:0]  a,
  input  logic [OW-1:0] b,
  output logic [W-1:0]  y
);

  localparam int SW = W + OW + 1;

  logic [SW-1:0] sum_s;
  logic          ovf_s;

  // Widened add, then clamp to the largest positive value on overflow.
  always_comb begin
    sum_s = {{(OW + 1){a[W-1]}}, a} + {{(W + 1){1'b0}}, b};
    ovf_s = ~sum_s[SW-1] & (|sum_s[SW-2:W-1]);
    if (ovf_s) begin
      y = {1'b0, {(W - 1){1'b1}}};
    end else begin
      y = sum_s[W-1:0];
    end
  end

endmodule

// File: rtl/interp_coord_gen.sv
// Coordinate-select producer: scans a BLOCK_W x BLOCK_H block from a signed
// base and issues four neighbour beats per pixel over valid/ready. All
// outputs come straight from registers.
module interp_coord_gen
  import interp_coord_pkg::*;
#(
  parameter int BLOCK_W = 8,
  parameter int BLOCK_H = 8,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] x_base,
  input  logic [COORD_W-1:0] y_base,
  input  logic               ready,
  output logic               valid,
  output logic [COORD_W-1:0] x_orig,
  output logic [COORD_W-1:0] x_inc,
  output logic [COORD_W-1:0] y_orig,
  output logic [COORD_W-1:0] y_inc,
  output logic               sel_x,
  output logic               sel_y,
  output logic               busy,
  output logic               done
);

  localparam int CW = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
  localparam int RW = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(BLOCK_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(BLOCK_H - 1);

  state_t             state_r, state_s;
  logic [CW-1:0]      col_r, col_s;
  logic [RW-1:0]      row_r, row_s;
  logic [1:0]         phase_r, phase_s;
  logic [COORD_W-1:0] x_base_r, x_base_s;
  logic [COORD_W-1:0] y_base_r, y_base_s;
  logic               fire_s, last_s;

  logic [COORD_W-1:0] x_orig_s, x_inc_s, y_orig_s, y_inc_s;

  logic               valid_r, busy_r, done_r, sel_x_r, sel_y_r;
  logic [COORD_W-1:0] x_orig_r, x_inc_r, y_orig_r, y_inc_r;

  assign fire_s = valid_r & ready;
  assign last_s = (row_r == ROW_LAST) && (col_r == COL_LAST) && (phase_r == PH_11);

  // Next-state and scan-counter advance; counters move only on a transfer.
  always_comb begin
    state_s  = state_r;
    col_s    = col_r;
    row_s    = row_r;
    phase_s  = phase_r;
    x_base_s = x_base_r;
    y_base_s = y_base_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s  = RUN;
          col_s    = {CW{1'b0}};
          row_s    = {RW{1'b0}};
          phase_s  = PH_00;
          x_base_s = x_base;
          y_base_s = y_base;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (fire_s) begin
          if (last_s) begin
            state_s = FIN;
          end else if (phase_r != PH_11) begin
            phase_s = phase_r + 2'd1;
          end else begin
            phase_s = PH_00;
            if (col_r == COL_LAST) begin
              col_s = {CW{1'b0}};
              row_s = row_r + RW'(1'b1);
            end else begin
              col_s = col_r + CW'(1'b1);
            end
          end
        end else begin
          state_s = RUN;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Coordinates for the beat that will be presented after this edge.
  coord_incr_sat #(.W(COORD_W), .OW(CW)) u_x_orig (.a(x_base_s), .b(col_s), .y(x_orig_s));
  coord_incr_sat #(.W(COORD_W), .OW(RW)) u_y_orig (.a(y_base_s), .b(row_s), .y(y_orig_s));
  coord_incr_sat #(.W(COORD_W), .OW(1))  u_x_inc  (.a(x_orig_s), .b(1'b1),  .y(x_inc_s));
  coord_incr_sat #(.W(COORD_W), .OW(1))  u_y_inc  (.a(y_orig_s), .b(1'b1),  .y(y_inc_s));

  // State, scan counters and latched bases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      col_r    <= {CW{1'b0}};
      row_r    <= {RW{1'b0}};
      phase_r  <= PH_00;
      x_base_r <= {COORD_W{1'b0}};
      y_base_r <= {COORD_W{1'b0}};
    end else begin
      state_r  <= state_s;
      col_r    <= col_s;
      row_r    <= row_s;
      phase_r  <= phase_s;
      x_base_r <= x_base_s;
      y_base_r <= y_base_s;
    end
  end

  // Output registers; a stalled beat reloads identical values, so it holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      sel_x_r  <= 1'b0;
      sel_y_r  <= 1'b0;
      x_orig_r <= {COORD_W{1'b0}};
      x_inc_r  <= {COORD_W{1'b0}};
      y_orig_r <= {COORD_W{1'b0}};
      y_inc_r  <= {COORD_W{1'b0}};
    end else if (state_s == RUN) begin
      valid_r  <= 1'b1;
      busy_r   <= 1'b1;
      done_r   <= 1'b0;
      sel_x_r  <= phase_s[0];
      sel_y_r  <= phase_s[1];
      x_orig_r <= x_orig_s;
      x_inc_r  <= x_inc_s;
      y_orig_r <= y_orig_s;
      y_inc_r  <= y_inc_s;
    end else begin
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= (state_s == FIN);
      sel_x_r  <= 1'b0;
      sel_y_r  <= 1'b0;
      x_orig_r <= {COORD_W{1'b0}};
      x_inc_r  <= {COORD_W{1'b0}};
      y_orig_r <= {COORD_W{1'b0}};
      y_inc_r  <= {COORD_W{1'b0}};
    end
  end

  assign valid  = valid_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign sel_x  = sel_x_r;
  assign sel_y  = sel_y_r;
  assign x_orig = x_orig_r;
  assign x_inc  = x_inc_r;
  assign y_orig = y_orig_r;
  assign y_inc  = y_inc_r;

endmodule

// File: tb/tb_interp_coord_gen.sv
// Self-checking bench for interp_coord_gen: a 4x3 instance for most scenarios
// and a 2x2 instance for the basic walk-through, checked against a reference
// model that derives each beat from its index.
module tb_interp_coord_gen;

  localparam int MW = 4;
  localparam int MH = 3;
  localparam int MN = 4 * MW * MH;
  localparam int SW = 2;
  localparam int SH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // main instance (4x3)
  logic       m_rst, m_start, m_ready;
  logic [7:0] m_xb, m_yb;
  logic       m_valid, m_sx, m_sy, m_busy, m_done;
  logic [7:0] m_xo, m_xi, m_yo, m_yi;
  logic [34:0] m_obs;
  assign m_obs = {m_valid, m_xo, m_xi, m_yo, m_yi, m_sy, m_sx};

  // small instance (2x2)
  logic       s_rst, s_start, s_ready;
  logic [7:0] s_xb, s_yb;
  logic       s_valid, s_sx, s_sy, s_busy, s_done;
  logic [7:0] s_xo, s_xi, s_yo, s_yi;
  logic [34:0] s_obs;
  assign s_obs = {s_valid, s_xo, s_xi, s_yo, s_yi, s_sy, s_sx};

  interp_coord_gen #(.BLOCK_W(MW), .BLOCK_H(MH), .COORD_W(8)) u_main (
    .clk(clk), .rst(m_rst), .start(m_start), .x_base(m_xb), .y_base(m_yb),
    .ready(m_ready), .valid(m_valid), .x_orig(m_xo), .x_inc(m_xi),
    .y_orig(m_yo), .y_inc(m_yi), .sel_x(m_sx), .sel_y(m_sy),
    .busy(m_busy), .done(m_done)
  );

  interp_coord_gen #(.BLOCK_W(SW), .BLOCK_H(SH), .COORD_W(8)) u_small (
    .clk(clk), .rst(s_rst), .start(s_start), .x_base(s_xb), .y_base(s_yb),
    .ready(s_ready), .valid(s_valid), .x_orig(s_xo), .x_inc(s_xi),
    .y_orig(s_yo), .y_inc(s_yi), .sel_x(s_sx), .sel_y(s_sy),
    .busy(s_busy), .done(s_done)
  );

  function automatic int sat127(int v);
    return (v > 127) ? 127 : v;
  endfunction

  // Expected beat k of a block: 4 phases per pixel, raster order, width w.
  function automatic logic [34:0] exp_beat(int bx, int by, int w, int k);
    int ph, pix, xo, xi, yo, yi;
    ph  = k % 4;
    pix = k / 4;
    xo  = sat127(bx + pix % w);
    yo  = sat127(by + pix / w);
    xi  = sat127(xo + 1);
    yi  = sat127(yo + 1);
    return {1'b1, xo[7:0], xi[7:0], yo[7:0], yi[7:0], ph[1:0]};
  endfunction

  function automatic int rand_coord();
    return int'($urandom_range(255, 0)) - 128;
  endfunction

  task automatic test_reset();
    int bx, by;
    @(negedge clk);
    total_cnt++;
    if ({m_obs, m_busy, m_done} !== 37'd0) $display("FAIL reset_main got %h exp 0", {m_obs, m_busy, m_done});
    else pass_cnt++;
    total_cnt++;
    if ({s_obs, s_busy, s_done} !== 37'd0) $display("FAIL reset_small got %h exp 0", {s_obs, s_busy, s_done});
    else pass_cnt++;
    m_rst = 1'b0;
    s_rst = 1'b0;
    bx = rand_coord();
    by = rand_coord();
    m_xb = 8'(bx);
    m_yb = 8'(by);
    m_ready = 1'b1;
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    for (int k = 0; k < 37; k++) @(negedge clk);
    total_cnt++;
    if ({m_obs, m_busy} !== {exp_beat(bx, by, MW, 37), 1'b1})
      $display("FAIL reset_beat37 got %h exp %h", {m_obs, m_busy}, {exp_beat(bx, by, MW, 37), 1'b1});
    else pass_cnt++;
    m_rst = 1'b1;
    #1;
    total_cnt++;
    if ({m_obs, m_busy, m_done} !== 37'd0) $display("FAIL reset_async got %h exp 0", {m_obs, m_busy, m_done});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({m_obs, m_busy, m_done} !== 37'd0) $display("FAIL reset_next_cycle got %h exp 0", {m_obs, m_busy, m_done});
    else pass_cnt++;
    m_rst = 1'b0;
    bx = rand_coord();
    by = rand_coord();
    m_xb = 8'(bx);
    m_yb = 8'(by);
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    total_cnt++;
    if (m_obs !== exp_beat(bx, by, MW, 0))
      $display("FAIL reset_restart got %h exp %h", m_obs, exp_beat(bx, by, MW, 0));
    else pass_cnt++;
    m_rst = 1'b1;
    @(negedge clk);
    m_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    s_xb = 8'd10;
    s_yb = 8'hFD;
    s_ready = 1'b1;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      if (c <= 16) begin
        total_cnt++;
        if ({s_obs, s_busy, s_done} !== {exp_beat(10, -3, SW, c - 1), 2'b10})
          $display("FAIL basic_beat%0d got %h exp %h", c - 1, {s_obs, s_busy, s_done}, {exp_beat(10, -3, SW, c - 1), 2'b10});
        else pass_cnt++;
      end else begin
        total_cnt++;
        if ({s_valid, s_busy, s_done} !== {2'b00, (c == 17)})
          $display("FAIL basic_done_c%0d got %b exp %b", c, {s_valid, s_busy, s_done}, {2'b00, (c == 17)});
        else pass_cnt++;
      end
      if (c == 1) begin
        total_cnt++;
        if ({s_xo, s_xi, s_yo, s_yi, s_sy, s_sx} !== {8'd10, 8'd11, 8'hFD, 8'hFE, 2'b00})
          $display("FAIL basic_first got %h exp %h", {s_xo, s_xi, s_yo, s_yi, s_sy, s_sx}, {8'd10, 8'd11, 8'hFD, 8'hFE, 2'b00});
        else pass_cnt++;
      end
      if (c == 16) begin
        total_cnt++;
        if ({s_xo, s_yo, s_sy, s_sx} !== {8'd11, 8'hFE, 2'b11})
          $display("FAIL basic_last got %h exp %h", {s_xo, s_yo, s_sy, s_sx}, {8'd11, 8'hFE, 2'b11});
        else pass_cnt++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    int by;
    by = 125;
    m_xb = 8'd126;
    m_yb = 8'(by);
    m_ready = 1'b1;
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    for (int k = 0; k < MN; k++) begin
      total_cnt++;
      if (m_obs !== exp_beat(126, by, MW, k) || m_xo[7] || m_xi[7] || m_yo[7] || m_yi[7])
        $display("FAIL sat_beat%0d got %h exp %h", k, m_obs, exp_beat(126, by, MW, k));
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if ({m_valid, m_busy, m_done} !== 3'b001) $display("FAIL sat_done got %b exp 001", {m_valid, m_busy, m_done});
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int bx, by, k;
    logic [3:0] pat;
    logic [34:0] prev;
    logic stalled;
    pat = 4'b1001;
    k = 0;
    stalled = 1'b0;
    prev = '0;
    bx = rand_coord();
    by = rand_coord();
    m_xb = 8'(bx);
    m_yb = 8'(by);
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    for (int c = 0; c < 400 && k < MN; c++) begin
      m_ready = pat[c % 4];
      if (stalled) begin
        total_cnt++;
        if (m_obs !== prev) $display("FAIL bp_hold got %h exp %h", m_obs, prev);
        else pass_cnt++;
      end
      if (m_valid && m_ready) begin
        total_cnt++;
        if (m_obs !== exp_beat(bx, by, MW, k)) $display("FAIL bp_beat%0d got %h exp %h", k, m_obs, exp_beat(bx, by, MW, k));
        else pass_cnt++;
        k++;
        stalled = 1'b0;
      end else begin
        stalled = m_valid;
      end
      prev = m_obs;
      @(negedge clk);
    end
    total_cnt++;
    if (k != MN || {m_valid, m_done} !== 2'b01)
      $display("FAIL bp_count got %0d beats done=%b exp %0d beats done=1", k, m_done, MN);
    else pass_cnt++;
    m_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int bx, by, done_cnt;
    done_cnt = 0;
    bx = int'($urandom_range(40, 0)) - 20;
    by = rand_coord();
    m_xb = 8'(bx);
    m_yb = 8'(by);
    m_ready = 1'b1;
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    for (int k = 0; k < MN; k++) begin
      total_cnt++;
      if (m_obs !== exp_beat(bx, by, MW, k)) $display("FAIL ign_beat%0d got %h exp %h", k, m_obs, exp_beat(bx, by, MW, k));
      else pass_cnt++;
      done_cnt += int'(m_done);
      m_start = (k == 3);
      if (k == 3) m_xb = 8'd50;
      @(negedge clk);
    end
    done_cnt += int'(m_done);
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      done_cnt += int'(m_done);
      total_cnt++;
      if ({m_valid, m_busy} !== 2'b00) $display("FAIL ign_fin_start got %b exp 00", {m_valid, m_busy});
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if (done_cnt != 1) $display("FAIL ign_done_count got %0d exp 1", done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int bx, by, bx2, by2, k;
    logic [34:0] prev;
    logic stalled;
    bx = rand_coord();
    by = rand_coord();
    m_xb = 8'(bx);
    m_yb = 8'(by);
    m_ready = 1'b1;
    m_start = 1'b1;
    @(negedge clk);
    for (int j = 0; j < MN; j++) begin
      total_cnt++;
      if (m_obs !== exp_beat(bx, by, MW, j)) $display("FAIL b2b_a_beat%0d got %h exp %h", j, m_obs, exp_beat(bx, by, MW, j));
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if ({m_valid, m_busy, m_done} !== 3'b001) $display("FAIL b2b_done got %b exp 001", {m_valid, m_busy, m_done});
    else pass_cnt++;
    bx2 = rand_coord();
    by2 = rand_coord();
    m_xb = 8'(bx2);
    m_yb = 8'(by2);
    @(negedge clk);
    total_cnt++;
    if ({m_valid, m_busy, m_done} !== 3'b000) $display("FAIL b2b_idle got %b exp 000", {m_valid, m_busy, m_done});
    else pass_cnt++;
    @(negedge clk);
    m_start = 1'b0;
    total_cnt++;
    if (m_obs !== exp_beat(bx2, by2, MW, 0)) $display("FAIL b2b_restart got %h exp %h", m_obs, exp_beat(bx2, by2, MW, 0));
    else pass_cnt++;
    k = 0;
    stalled = 1'b0;
    prev = '0;
    for (int c = 0; c < 600 && k < MN; c++) begin
      m_ready = 1'($urandom_range(1, 0));
      if (stalled) begin
        total_cnt++;
        if (m_obs !== prev) $display("FAIL b2b_hold got %h exp %h", m_obs, prev);
        else pass_cnt++;
      end
      if (m_valid && m_ready) begin
        total_cnt++;
        if (m_obs !== exp_beat(bx2, by2, MW, k)) $display("FAIL b2b_b_beat%0d got %h exp %h", k, m_obs, exp_beat(bx2, by2, MW, k));
        else pass_cnt++;
        k++;
        stalled = 1'b0;
      end else begin
        stalled = m_valid;
      end
      prev = m_obs;
      @(negedge clk);
    end
    total_cnt++;
    if (k != MN || {m_valid, m_done} !== 2'b01)
      $display("FAIL b2b_count got %0d beats done=%b exp %0d beats done=1", k, m_done, MN);
    else pass_cnt++;
    m_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    m_rst = 1'b1;  s_rst = 1'b1;
    m_start = 1'b0; s_start = 1'b0;
    m_ready = 1'b0; s_ready = 1'b0;
    m_xb = 8'd0; m_yb = 8'd0; s_xb = 8'd0; s_yb = 8'd0;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_start_ignored();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, %0d/%0d done", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
